// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types: reset/step constants, FSM encoding, IF/ID payload struct.
// The exc_adel payload bit and unaligned PC loads exist only when IF_MISALIGN_EXC_EN is defined.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;
  localparam logic [31:0] NOP_INST         = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        dslot;
`ifdef IF_MISALIGN_EXC_EN
    logic        exc_adel;
`endif
  } ifid_t;

  // Every value written into the PC passes through here.
  function automatic logic [31:0] pc_load(input logic [31:0] addr);
`ifdef IF_MISALIGN_EXC_EN
    return addr;
`else
    return addr & 32'hFFFF_FFFC;
`endif
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: imem req/ack bus, decode feedback (stall, branch) and IF/ID outputs.
// master = fetch stage, slave = memory/decode side; id_exc_adel_o only with IF_MISALIGN_EXC_EN.
interface if_stage_if;

  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_inst_o;
  logic        id_valid_o;
  logic        id_is_in_delayslot_o;
  logic        fetch_busy_o;
`ifdef IF_MISALIGN_EXC_EN
  logic        id_exc_adel_o;
`endif

  modport master (
    input  stall_i, branch_flag_i, branch_target_address_i, imem_ack_i, imem_rdata_i,
    output imem_req_o, imem_addr_o, id_pc_o, id_inst_o, id_valid_o,
           id_is_in_delayslot_o, fetch_busy_o
`ifdef IF_MISALIGN_EXC_EN
    , output id_exc_adel_o
`endif
  );

  modport slave (
    output stall_i, branch_flag_i, branch_target_address_i, imem_ack_i, imem_rdata_i,
    input  imem_req_o, imem_addr_o, id_pc_o, id_inst_o, id_valid_o,
           id_is_in_delayslot_o, fetch_busy_o
`ifdef IF_MISALIGN_EXC_EN
    , input id_exc_adel_o
`endif
  );

endinterface

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or freeze.
// One-cycle latency; holds every field whenever neither load nor bubble is asserted.
module if_stage_if_id_reg
  import if_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t load_dat,
  output ifid_t q
);

  // A bubble keeps the old pc so decode still sees a sensible address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= load_dat;
    end else if (bubble) begin
      q.inst     <= NOP_INST;
      q.valid    <= 1'b0;
      q.dslot    <= 1'b0;
`ifdef IF_MISALIGN_EXC_EN
      q.exc_adel <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch + IF/ID: PC sequencing, imem req/ack, delayed-branch redirect (IF_MISALIGN_EXC_EN adds ADEL path).
// 1 inst/cycle on zero-wait memory; stall_i freezes pc and IF/ID, an issued fetch still lands in the hold buffer.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
)(
  input logic        clk,
  input logic        rst_n,
  if_stage_if.master bus
);

  fetch_state_t state, state_nxt;

  logic [31:0] pc, pc_nxt;
  logic        redirect_pending;
  logic [31:0] redirect_target;
  logic [31:0] hold_inst, hold_pc;

  logic        misaligned;
  logic        req, busy, deliver, capture, exc_dlv;
  logic [31:0] dlv_pc, dlv_inst;
  logic        advance, br_take;
  ifid_t       id_d, id_q;

`ifdef IF_MISALIGN_EXC_EN
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Decode's branch inputs only mean something when its instruction moves on.
  assign advance = id_q.valid && !bus.stall_i;
  assign br_take = bus.branch_flag_i && advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: if (!misaligned && bus.imem_ack_i && bus.stall_i) state_nxt = S_HOLD;
      S_HOLD:  if (!bus.stall_i) state_nxt = S_FETCH;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_comb begin
    req      = 1'b0;
    busy     = 1'b0;
    deliver  = 1'b0;
    capture  = 1'b0;
    exc_dlv  = 1'b0;
    dlv_pc   = pc;
    dlv_inst = bus.imem_rdata_i;
    case (state)
      S_FETCH: begin
        if (misaligned) begin
          deliver  = !bus.stall_i;
          exc_dlv  = 1'b1;
          dlv_inst = NOP_INST;
        end else begin
          req     = 1'b1;
          busy    = !bus.imem_ack_i;
          deliver = bus.imem_ack_i && !bus.stall_i;
          capture = bus.imem_ack_i && bus.stall_i;
        end
      end
      S_HOLD: begin
        deliver  = !bus.stall_i;
        dlv_pc   = hold_pc;
        dlv_inst = hold_inst;
      end
      default: ;
    endcase
  end

  // A pending redirect outranks a same-cycle branch: the delay slot is the one being delivered.
  always_comb begin
    pc_nxt = pc;
    if (deliver) begin
      if (redirect_pending) begin
        pc_nxt = pc_load(redirect_target);
      end else if (br_take) begin
        pc_nxt = pc_load(bus.branch_target_address_i);
      end else if (!exc_dlv) begin
        pc_nxt = pc_load(dlv_pc + PC_STEP);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc               <= pc_load(RESET_PC);
      redirect_pending <= 1'b0;
      redirect_target  <= 32'h0;
      hold_inst        <= 32'h0;
      hold_pc          <= 32'h0;
    end else begin
      pc <= pc_nxt;
      if (capture) begin
        hold_inst <= bus.imem_rdata_i;
        hold_pc   <= pc;
      end
      if (deliver) begin
        redirect_pending <= 1'b0;
      end else if (br_take) begin
        redirect_pending <= 1'b1;
        redirect_target  <= bus.branch_target_address_i;
      end
    end
  end

  always_comb begin
    id_d          = '0;
    id_d.pc       = dlv_pc;
    id_d.inst     = dlv_inst;
    id_d.valid    = 1'b1;
    id_d.dslot    = redirect_pending | br_take;
`ifdef IF_MISALIGN_EXC_EN
    id_d.exc_adel = exc_dlv;
`endif
  end

  if_stage_if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (deliver),
    .bubble   (advance && !deliver),
    .load_dat (id_d),
    .q        (id_q)
  );

  assign bus.imem_req_o           = req;
  assign bus.imem_addr_o          = pc;
  assign bus.fetch_busy_o         = busy;
  assign bus.id_pc_o              = id_q.pc;
  assign bus.id_inst_o            = id_q.inst;
  assign bus.id_valid_o           = id_q.valid;
  assign bus.id_is_in_delayslot_o = id_q.dslot;
`ifdef IF_MISALIGN_EXC_EN
  assign bus.id_exc_adel_o        = id_q.exc_adel;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then a randomized phase, checked every cycle
// against a program-order model (fetched-instruction buffer, delay-slot bookkeeping).
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst_n;

  if_stage_if bus ();

  if_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: what decode should hold, what the next fetch address must be.
  logic [31:0] e_pc, e_inst;
  logic        e_valid, e_ds;
  logic        have;
  logic [31:0] f_addr;
  logic        pend_ds;
  logic [31:0] pend_tgt;
  logic [31:0] exp_fetch;
  logic        booting;

  // Memory responder knobs.
  int   age, lat, lat_fixed;
  bit   lat_rand;
  logic last_ack, seen_108, seen_wrap0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    e_pc = 32'h0; e_inst = 32'h0; e_valid = 1'b0; e_ds = 1'b0;
    have = 1'b0; f_addr = 32'h0; pend_ds = 1'b0; pend_tgt = 32'h0;
    exp_fetch = RST_PC; booting = 1'b1; age = 0;
  endtask

  // One clock: drive at negedge, check at negedge+1, then advance the model over the next posedge.
  task automatic cycle(input logic st, input logic bf, input logic [31:0] bt, input logic stray);
    logic        req, ack, exp_req, br;
    logic [31:0] addr;
    @(negedge clk);
    req  = bus.imem_req_o;
    addr = bus.imem_addr_o;
    if (req) begin
      if (age == 0) lat = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
      ack = (age >= lat);
    end else begin
      ack = stray;
    end
    bus.stall_i                 = st;
    bus.branch_flag_i           = bf;
    bus.branch_target_address_i = bt;
    bus.imem_ack_i              = ack;
    bus.imem_rdata_i            = mem_word(addr);
    #1;
    exp_req = !booting && !have;
    chk1("imem_req", bus.imem_req_o, exp_req);
    if (exp_req) chk32("imem_addr", bus.imem_addr_o, exp_fetch);
    chk1("fetch_busy", bus.fetch_busy_o, exp_req && !ack);
    chk32("id_pc", bus.id_pc_o, e_pc);
    chk32("id_inst", bus.id_inst_o, e_inst);
    chk1("id_valid", bus.id_valid_o, e_valid);
    chk1("id_dslot", bus.id_is_in_delayslot_o, e_ds);
    if (req && addr == 32'h108) seen_108 = 1'b1;
    if (req && ack && addr == 32'h0) seen_wrap0 = 1'b1;
    last_ack = req && ack;
    if (req && !ack) age++; else age = 0;

    if (booting) begin
      booting = 1'b0;
    end else begin
      if (exp_req && ack) begin
        have   = 1'b1;
        f_addr = exp_fetch;
      end
      br = bf && e_valid && !st;
      if (br) begin
        pend_ds  = 1'b1;
        pend_tgt = bt & 32'hFFFF_FFFC;
      end
      if (!st) begin
        if (have) begin
          e_pc      = f_addr;
          e_inst    = mem_word(f_addr);
          e_valid   = 1'b1;
          e_ds      = pend_ds;
          exp_fetch = pend_ds ? pend_tgt : f_addr + 32'd4;
          pend_ds   = 1'b0;
          have      = 1'b0;
        end else if (e_valid) begin
          e_valid = 1'b0;
          e_inst  = 32'h0;
          e_ds    = 1'b0;
        end
      end
    end
  endtask

  // Assert branch_flag_i on the first advancing decode instruction matching src (or any).
  task automatic branch_at(input logic any, input logic [31:0] src, input logic [31:0] tgt);
    logic done, hit;
    done = 1'b0;
    for (int i = 0; i < 24 && !done; i++) begin
      hit = e_valid && (any || e_pc == src);
      cycle(1'b0, hit, tgt, 1'b0);
      done = hit;
    end
    chk1("branch_issued", done, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("rst_req", bus.imem_req_o, 1'b0);
    chk32("rst_addr", bus.imem_addr_o, RST_PC);
    chk32("rst_id_pc", bus.id_pc_o, 32'h0);
    chk32("rst_id_inst", bus.id_inst_o, 32'h0);
    chk1("rst_id_valid", bus.id_valid_o, 1'b0);
    chk1("rst_id_dslot", bus.id_is_in_delayslot_o, 1'b0);
    model_reset();
    bus.imem_ack_i    = 1'b0;
    bus.stall_i       = 1'b0;
    bus.branch_flag_i = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.stall_i = 1'b0;
    bus.branch_flag_i = 1'b0;
    bus.branch_target_address_i = 32'h0;
    bus.imem_ack_i = 1'b0;
    bus.imem_rdata_i = 32'h0;
    lat_fixed = 0; lat_rand = 1'b0; lat = 0;
    last_ack = 1'b0; seen_108 = 1'b0; seen_wrap0 = 1'b0;
    model_reset();

    #12;
    chk1("reset_req", bus.imem_req_o, 1'b0);
    chk32("reset_addr", bus.imem_addr_o, RST_PC);
    chk32("reset_id_pc", bus.id_pc_o, 32'h0);
    chk32("reset_id_inst", bus.id_inst_o, 32'h0);
    chk1("reset_id_valid", bus.id_valid_o, 1'b0);
    chk1("reset_id_dslot", bus.id_is_in_delayslot_o, 1'b0);
    chk1("reset_busy", bus.fetch_busy_o, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Zero-wait memory stream from the reset vector.
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Three-cycle memory latency: held address, busy, bubbles.
    lat_fixed = 3;
    repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Branch into 0x100, then 0x100 -> 0x200: 0x104 is the delay slot, 0x108 never fetched.
    lat_fixed = 0;
    branch_at(1'b1, 32'h0, 32'h100);
    seen_108 = 1'b0;
    branch_at(1'b0, 32'h100, 32'h200);
    @(posedge clk);
    #2;
    chk32("dslot_pc", bus.id_pc_o, 32'h104);
    chk1("dslot_flag", bus.id_is_in_delayslot_o, 1'b1);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("no_fetch_108", seen_108, 1'b0);

    // Branch resolved while the delay-slot fetch is still waiting for ack.
    lat_fixed = 2;
    branch_at(1'b1, 32'h0, 32'h400);
    repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Stall four cycles with ack landing in the second.
    lat_fixed = 1;
    last_ack = 1'b0;
    for (int i = 0; i < 5 && !last_ack; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("stall_setup", last_ack, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #2;
    chk1("hold_req_low", bus.imem_req_o, 1'b0);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // PC wrap at the top of the address space, then an unaligned target.
    lat_fixed = 0;
    seen_wrap0 = 1'b0;
    branch_at(1'b1, 32'h0, 32'hFFFF_FFF8);
    repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    chk1("pc_wrap", seen_wrap0, 1'b1);
    branch_at(1'b1, 32'h0, 32'h0000_0302);
    repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Reset in the middle of a slow request, stray ack right after release.
    lat_fixed = 3;
    repeat (2) cycle(1'b0, 1'b0, 32'h0, 1'b0);
    do_reset();
    lat_fixed = 0;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    repeat (5) cycle(1'b0, 1'b0, 32'h0, 1'b0);

    // Randomized stalls, latencies, branches and stray acks.
    lat_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
